// File: rtl/seq_muldiv_alu.sv
// ---------------------------------------------------------------------------
// seq_muldiv_alu
//
// Multi-cycle execute unit for the RV32M multiply/divide group. Multiplies
// with a radix-2 shift-add loop and divides with a restoring loop, both on
// operand magnitudes, then applies sign correction in a single finish cycle.
// Results leave through a valid/ready handshake and are held until consumed.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operation request
//   in_ready   unit can accept a request (high only in IDLE)
//   op[2:0]    funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//              100 DIV, 101 DIVU, 110 REM, 111 REMU
//   a, b       rs1 / rs2 operands (XLEN bits)
//   out_valid  result available
//   out_ready  consumer accepts result
//   result     operation result (XLEN bits), held between operations
//
// Optional build macro:
//   MULDIV_EARLY_OUT_EN  when defined, divide-by-zero and multiply-by-zero
//                        skip the iteration loop and finish one edge after
//                        accept. Results are unchanged.
// ---------------------------------------------------------------------------
module seq_muldiv_alu #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // Conditional two's-complement negation helpers.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] x,
                                                 input logic neg);
        return neg ? (~x + XLEN'(1)) : x;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] x,
                                                    input logic neg);
        return neg ? (~x + (2*XLEN)'(1)) : x;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t            state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [2:0]        op_q,        op_d;
    logic              sign_a_q,    sign_a_d;
    logic              sign_b_q,    sign_b_d;
    logic              div0_q,      div0_d;
    logic              ovf_q,       ovf_d;
    logic              mzero_q,     mzero_d;
    logic [XLEN-1:0]   a_q,         a_d;
    logic [XLEN-1:0]   mc_q,        mc_d;    // multiplicand / divisor magnitude
    logic [XLEN-1:0]   hi_q,        hi_d;    // product high / partial remainder
    logic [XLEN-1:0]   lo_q,        lo_d;    // multiplier bits / quotient bits
    logic              in_ready_q,  in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   result_q,    result_d;

    // -----------------------------------------------------------------------
    // Accept-time decode
    // -----------------------------------------------------------------------
    logic            a_signed_op;
    logic            b_signed_op;
    logic            sa_in;
    logic            sb_in;
    logic            early_out;

    // Divide ops are signed when funct3[0]=0; multiplies: a is signed unless
    // MULHU, b only for MUL/MULH.
    assign a_signed_op = op[2] ? ~op[0] : (op[1:0] != 2'b11);
    assign b_signed_op = op[2] ? ~op[0] : ~op[1];
    assign sa_in       = a_signed_op & a[XLEN-1];
    assign sb_in       = b_signed_op & b[XLEN-1];

`ifdef MULDIV_EARLY_OUT_EN
    assign early_out = op[2] ? (b == '0) : ((a == '0) || (b == '0));
`else
    assign early_out = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Iteration datapath
    // -----------------------------------------------------------------------
    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   shl;
    logic [XLEN:0]   trial;

    assign add_sum = {1'b0, hi_q} + {1'b0, mc_q};
    assign shl     = {hi_q, lo_q[XLEN-1]};
    // Non-negative trial difference means the divisor fits this step; the
    // partial remainder is always below the divisor, so bit XLEN is a clean
    // borrow flag.
    assign trial   = shl - {1'b0, mc_q};

    // -----------------------------------------------------------------------
    // Finish-stage sign correction and result selection
    // -----------------------------------------------------------------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fin_res;

    assign prod_fix = cond_neg2({hi_q, lo_q}, sign_a_q ^ sign_b_q);
    assign quot_fix = cond_neg(lo_q, sign_a_q ^ sign_b_q);
    assign rem_fix  = cond_neg(hi_q, sign_a_q);

    always_comb begin
        fin_res = '0;
        if (op_q[2]) begin
            if (div0_q) begin
                fin_res = op_q[1] ? a_q : '1;
            end else if (ovf_q) begin
                fin_res = op_q[1] ? '0 : a_q;
            end else begin
                fin_res = op_q[1] ? rem_fix : quot_fix;
            end
        end else if (mzero_q) begin
            fin_res = '0;
        end else if (op_q[1:0] == 2'b00) begin
            fin_res = prod_fix[XLEN-1:0];
        end else begin
            fin_res = prod_fix[2*XLEN-1:XLEN];
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        div0_d      = div0_q;
        ovf_d       = ovf_q;
        mzero_d     = mzero_q;
        a_d         = a_q;
        mc_d        = mc_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    op_d       = op;
                    a_d        = a;
                    sign_a_d   = sa_in;
                    sign_b_d   = sb_in;
                    div0_d     = op[2] && (b == '0);
                    ovf_d      = op[2] && !op[0] && (a == MOST_NEG) && (b == '1);
                    mzero_d    = !op[2] && ((a == '0) || (b == '0));
                    // Multiply: mc=|a|, lo=|b| (shifted out LSB first).
                    // Divide:   mc=|b|, lo=|a| (shifted out MSB first).
                    mc_d       = op[2] ? cond_neg(b, sb_in) : cond_neg(a, sa_in);
                    lo_d       = op[2] ? cond_neg(a, sa_in) : cond_neg(b, sb_in);
                    hi_d       = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = early_out ? S_FINISH : S_CALC;
                end
            end

            S_CALC: begin
                if (op_q[2]) begin
                    hi_d = trial[XLEN] ? shl[XLEN-1:0] : trial[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], ~trial[XLEN]};
                end else begin
                    if (lo_q[0]) begin
                        hi_d = add_sum[XLEN:1];
                        lo_d = {add_sum[0], lo_q[XLEN-1:1]};
                    end else begin
                        hi_d = {1'b0, hi_q[XLEN-1:1]};
                        lo_d = {hi_q[0], lo_q[XLEN-1:1]};
                    end
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = S_FINISH;
                end
            end

            S_FINISH: begin
                result_d    = fin_res;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end

            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            div0_q      <= 1'b0;
            ovf_q       <= 1'b0;
            mzero_q     <= 1'b0;
            a_q         <= '0;
            mc_q        <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            div0_q      <= div0_d;
            ovf_q       <= ovf_d;
            mzero_q     <= mzero_d;
            a_q         <= a_d;
            mc_q        <= mc_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_seq_muldiv_alu.sv
module tb_seq_muldiv_alu;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    seq_muldiv_alu #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;
    exp_t exp_q[$];

    logic auto_rdy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: RV32M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] x,
                                           input logic [31:0] y);
        longint          sx, sy, p, q;
        longint unsigned ux, uy, up;
        logic [63:0]     v;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            3'd0: begin p = sx * sy; v = p; return v[31:0]; end
            3'd1: begin p = sx * sy; v = p; return v[63:32]; end
            3'd2: begin p = sx * longint'(uy); v = p; return v[63:32]; end
            3'd3: begin up = ux * uy; v = up; return v[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                q = sx / sy; v = q; return v[31:0];
            end
            3'd5: begin
                if (y == 0) return 32'hFFFF_FFFF;
                return x / y;
            end
            3'd6: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
                q = sx % sy; v = q; return v[31:0];
            end
            default: begin
                if (y == 0) return x;
                return x % y;
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] x,
                                   input logic [31:0] y);
`ifdef MULDIV_EARLY_OUT_EN
        if (o[2] && y == 0) return 1;
        if (!o[2] && (x == 0 || y == 0)) return 1;
`endif
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Holds in_valid high until an edge where in_ready was high, then logs
    // the expected response. Called at #1 after a rising edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic rdy_before;
        int   n;
        op = o; a = x; b = y; in_valid = 1'b1;
        n = 0;
        forever begin
            rdy_before = in_ready;
            @(posedge clk); #1;
            if (rdy_before) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 32'd0, 32'd1);
                in_valid = 1'b0;
                return;
            end
        end
        exp_q.push_back('{res: ref_op(o, x, y), lat: exp_lat(o, x, y), acc: cyc});
        in_valid = 1'b0;
        op = 3'($urandom); a = $urandom; b = $urandom;
        chk("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
    endtask

    always @(posedge clk) begin
        #1;
        if (auto_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: samples on the falling edge, pops the scoreboard on handshake.
    logic        prev_ov  = 1'b0;
    logic        prev_hs  = 1'b0;
    logic [31:0] prev_res = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov <= 1'b0;
            prev_hs <= 1'b0;
        end else begin
            if (exp_q.size() > 0) chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
            if (prev_hs) begin
                chk("valid_drop_after_release", {31'd0, out_valid}, 32'd0);
            end else if (prev_ov) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_result", result, prev_res);
            end
            if (out_valid && !prev_ov) begin
                if (exp_q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
                else chk("latency", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_handshake", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("result", result, e.res);
                end
            end
            prev_ov  <= out_valid;
            prev_hs  <= out_valid && out_ready;
            prev_res <= result;
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0;
        out_ready = 1'b1; auto_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        issue(3'd0, 32'd7, 32'hFFFF_FFFD);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(3'd2, 32'hFFFF_FFFF, 32'h0000_0002);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2);
        issue(3'd5, 32'd100, 32'd7);
        issue(3'd7, 32'd100, 32'd7);
        issue(3'd4, 32'd5, 32'd0);
        issue(3'd6, 32'd5, 32'd0);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(3'd0, 32'd0, 32'd1234);

        // Backpressure: hold out_ready low for 5 cycles after out_valid
        begin
            int n;
            n = 0;
            while (exp_q.size() > 0 && n < 1000) begin @(posedge clk); #1; n++; end
            auto_rdy = 1'b0;
            out_ready = 1'b0;
            issue(3'd0, 32'h1234, 32'h10);
            n = 0;
            while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
            chk("bp_valid_seen", {31'd0, out_valid}, 32'd1);
            repeat (5) @(posedge clk);
            #1;
            chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
            out_ready = 1'b1;
            @(posedge clk); #1;
            chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
            chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
            auto_rdy = 1'b1;
            issue(3'd0, 32'd3, 32'd4);
        end

        // Reset in the middle of a divide
        begin
            int n;
            n = 0;
            while (exp_q.size() > 0 && n < 1000) begin @(posedge clk); #1; n++; end
            issue(3'd4, 32'h1234_5678, 32'd7);
            repeat (10) begin @(posedge clk); #1; end
            rst_n = 1'b0;
            exp_q.delete();
            #1;
            chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
            chk("midrst_result", result, 32'd0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(posedge clk); #1;
            issue(3'd5, 32'd9, 32'd3);
        end

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick());
        end

        begin
            int n;
            n = 0;
            while (exp_q.size() > 0 && n < 3000) begin @(posedge clk); #1; n++; end
            if (exp_q.size() > 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        end
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_muldiv_alu.md
Name: seq_muldiv_alu

Overview:
Parametrised multi-cycle execute unit. Implements the RV32M multiply/divide operations that the single-cycle integer ALU does not cover.
Uses radix-2 iterative shift-add multiplication and restoring division on operand magnitudes, with sign fix-up at the end.
Sits beside the combinational ALU in the execute stage. Exchanges operands and results with the core over valid/ready handshakes, so the core stalls while the unit is busy.

Parameters:
XLEN, 32, operand and result width in bits (any value ≥ 4).
CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  unit can accept a request
op  in  3  funct3 code: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
a  in  XLEN  rs1 operand
b  in  XLEN  rs2 operand
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
result  out  XLEN  operation result

Behaviour:
- Reset (async assert, sync deassert by design use):
  - state=IDLE; in_ready=1; out_valid=0; result=0.
  - All internal registers cleared. Reset mid-operation aborts it with no output.
- States:
  - IDLE -> CALC on accept edge E0 (in_valid&&in_ready). Latches op, sign flags, |a|, |b|, special-case flags. Sets cnt=0.
  - CALC: one iteration per edge. After the edge where cnt==XLEN-1, go to FINISH. CALC therefore occupies edges E0+1..E0+XLEN.
  - FINISH: one edge (E0+XLEN+1). Applies sign correction, selects high/low half or quotient/remainder, registers result, sets out_valid=1. Goes to DONE.
  - DONE: out_valid=1 and result held stable until out_ready=1. On that edge: out_valid=0, go to IDLE.
- in_ready=1 only in IDLE; no new request is accepted in the DONE release cycle.
- op, a and b are ignored outside the accept edge.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- Multiply:
  - 2*XLEN product of magnitudes, negated in FINISH if operand signs differ.
  - MUL returns low XLEN bits; MULH* return high XLEN bits.
- Divide/remainder:
  - Quotient is negated if signs differ; remainder takes the dividend's sign (truncating division).
- Special cases, forced in FINISH and overriding the datapath:
  - b==0: DIV/DIVU = all ones; REM/REMU = a.
  - DIV with a=most-negative, b=-1: quotient = a; REM = 0.
- result holds its last value between operations.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: on accept, if the op is a divide with b==0, or a multiply with a==0 or b==0, skip CALC.
  - The edge after E0 performs FINISH; out_valid rises at E0+1.
  - Results are identical to the full path.
- Undefined: every operation takes the fixed XLEN+1-edge latency.

Test Plan (XLEN=32, macro undefined unless stated):
- MUL a=7, b=0xFFFFFFFD (-3) -> result 0xFFFFFFEB; out_valid rises exactly 33 edges after accept; in_ready=0 throughout.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0. With MULDIV_EARLY_OUT_EN: the /0 cases complete with out_valid at E0+1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result and out_valid stable, in_ready=0. Release -> IDLE next edge, then back-to-back MUL 3*4 -> 12.
- Assert rst_n=0 at cnt=10 of a DIV -> out_valid=0, in_ready=1 immediately. After release, DIVU 9/3 -> 3 with normal latency.
